// File: rtl/dllp_rx_decode.sv
// DLLP receive decoder: frames 2-beat DLLPs from AXIS and emits Ack/Nak and flow-control strobes.
// Optional CRC-16 checking of bytes 4-5 is enabled by defining DLLP_RX_CRC_CHECK_EN.
module dllp_rx_decode #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            link_status_i,
  input  logic [DATA_WIDTH-1:0] s_axis_dllp_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_dllp_tkeep_i,
  input  logic                  s_axis_dllp_tvalid_i,
  input  logic                  s_axis_dllp_tlast_i,
  input  logic [USER_WIDTH-1:0] s_axis_dllp_tuser_i,
  output logic                  s_axis_dllp_tready_o,
  output logic                  ack_valid_o,
  output logic                  ack_nak_o,
  output logic [11:0]           ack_seq_o,
  output logic                  fc_valid_o,
  output logic [1:0]            fc_kind_o,
  output logic [1:0]            fc_type_o,
  output logic [2:0]            fc_vc_o,
  output logic [7:0]            fc_hdr_o,
  output logic [11:0]           fc_data_o,
  output logic                  bad_dllp_o
);

  typedef enum logic [1:0] {StIdle, StBeat2, StIssue, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] hdr_q, hdr_d;
  logic        ack_valid_q, ack_valid_d, fc_valid_q, fc_valid_d, bad_q, bad_d;
  logic        ack_nak_q, ack_nak_d;
  logic [11:0] ack_seq_q, ack_seq_d;
  logic [1:0]  fc_kind_q, fc_kind_d, fc_type_q, fc_type_d;
  logic [2:0]  fc_vc_q, fc_vc_d;
  logic [7:0]  fc_hdr_q, fc_hdr_d;
  logic [11:0] fc_data_q, fc_data_d;

  logic       hs, keep_full, keep_low2, is_ack, is_fc, crc_bad;
  logic [7:0] b0, b1, b2, b3;
  logic [1:0] kind;
  logic       unused_user;

  assign unused_user = ^s_axis_dllp_tuser_i;

  assign {b3, b2, b1, b0} = hdr_q;
  assign s_axis_dllp_tready_o = ~rst_i & (state_q != StIssue);
  assign hs        = s_axis_dllp_tvalid_i & s_axis_dllp_tready_o;
  assign keep_full = (s_axis_dllp_tkeep_i == KEEP_WIDTH'(4'hf));
  assign keep_low2 = (s_axis_dllp_tkeep_i == KEEP_WIDTH'(4'h3));

`ifdef DLLP_RX_CRC_CHECK_EN
  // Serial CRC over bytes 0-3, LSB first; result inverted and bit-reversed into bytes 4-5.
  function automatic logic [15:0] dllp_crc(input logic [31:0] d);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hffff;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100b : 16'h0000);
    end
    c = ~c;
    for (int i = 0; i < 8; i++) begin
      r[i]     = c[15-i];
      r[8+i]   = c[7-i];
    end
    return r;
  endfunction

  assign crc_bad = (dllp_crc(hdr_q) != s_axis_dllp_tdata_i[15:0]);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    kind = 2'b00;
    case (b0[7:6])
      2'b01:   kind = 2'b01;
      2'b11:   kind = 2'b10;
      2'b10:   kind = 2'b11;
      default: kind = 2'b00;
    endcase
  end

  assign is_ack = (b0 == 8'h00) || (b0 == 8'h10);
  assign is_fc  = ~b0[3] && (b0[5:4] != 2'b11) && (kind != 2'b00);

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    ack_valid_d = 1'b0;
    fc_valid_d  = 1'b0;
    bad_d       = 1'b0;
    ack_nak_d   = ack_nak_q;
    ack_seq_d   = ack_seq_q;
    fc_kind_d   = fc_kind_q;
    fc_type_d   = fc_type_q;
    fc_vc_d     = fc_vc_q;
    fc_hdr_d    = fc_hdr_q;
    fc_data_d   = fc_data_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          if (s_axis_dllp_tlast_i) begin
            bad_d = 1'b1;
          end else if (!keep_full) begin
            bad_d   = 1'b1;
            state_d = StDrain;
          end else begin
            hdr_d   = s_axis_dllp_tdata_i[31:0];
            state_d = StBeat2;
          end
        end
      end
      StBeat2: begin
        if (hs) begin
          if (!s_axis_dllp_tlast_i || !keep_low2) begin
            bad_d   = 1'b1;
            // A bad beat that already carries tlast ends the packet itself.
            state_d = s_axis_dllp_tlast_i ? StIdle : StDrain;
          end else begin
            state_d = StIssue;
            if (crc_bad) begin
              bad_d = 1'b1;
            end else if (is_ack && link_status_i == 2'b10) begin
              ack_valid_d = 1'b1;
              ack_nak_d   = b0[4];
              ack_seq_d   = {b2[3:0], b3};
            end else if (is_fc && (link_status_i == 2'b01 || link_status_i == 2'b10)) begin
              fc_valid_d = 1'b1;
              fc_kind_d  = kind;
              fc_type_d  = b0[5:4];
              fc_vc_d    = b0[2:0];
              fc_hdr_d   = {b1[5:0], b2[7:6]};
              fc_data_d  = {b2[3:0], b3};
            end
          end
        end
      end
      StIssue: state_d = StIdle;
      StDrain: begin
        if (hs && s_axis_dllp_tlast_i) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      hdr_q       <= '0;
      ack_valid_q <= 1'b0;
      fc_valid_q  <= 1'b0;
      bad_q       <= 1'b0;
      ack_nak_q   <= 1'b0;
      ack_seq_q   <= '0;
      fc_kind_q   <= '0;
      fc_type_q   <= '0;
      fc_vc_q     <= '0;
      fc_hdr_q    <= '0;
      fc_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      ack_valid_q <= ack_valid_d;
      fc_valid_q  <= fc_valid_d;
      bad_q       <= bad_d;
      ack_nak_q   <= ack_nak_d;
      ack_seq_q   <= ack_seq_d;
      fc_kind_q   <= fc_kind_d;
      fc_type_q   <= fc_type_d;
      fc_vc_q     <= fc_vc_d;
      fc_hdr_q    <= fc_hdr_d;
      fc_data_q   <= fc_data_d;
    end
  end

  assign ack_valid_o = ack_valid_q;
  assign ack_nak_o   = ack_nak_q;
  assign ack_seq_o   = ack_seq_q;
  assign fc_valid_o  = fc_valid_q;
  assign fc_kind_o   = fc_kind_q;
  assign fc_type_o   = fc_type_q;
  assign fc_vc_o     = fc_vc_q;
  assign fc_hdr_o    = fc_hdr_q;
  assign fc_data_o   = fc_data_q;
  assign bad_dllp_o  = bad_q;

endmodule

// File: tb/tb_dllp_rx_decode.sv
// Randomized bench for dllp_rx_decode against a packet-level reference model.
module tb_dllp_rx_decode;

`ifdef DLLP_RX_CRC_CHECK_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  link_status_i = 2'b00;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [3:0]  tuser = '0;
  logic        tready;
  logic        ack_valid_o, ack_nak_o, fc_valid_o, bad_dllp_o;
  logic [11:0] ack_seq_o, fc_data_o;
  logic [1:0]  fc_kind_o, fc_type_o;
  logic [2:0]  fc_vc_o;
  logic [7:0]  fc_hdr_o;

  dllp_rx_decode dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .link_status_i        (link_status_i),
    .s_axis_dllp_tdata_i  (tdata),
    .s_axis_dllp_tkeep_i  (tkeep),
    .s_axis_dllp_tvalid_i (tvalid),
    .s_axis_dllp_tlast_i  (tlast),
    .s_axis_dllp_tuser_i  (tuser),
    .s_axis_dllp_tready_o (tready),
    .ack_valid_o          (ack_valid_o),
    .ack_nak_o            (ack_nak_o),
    .ack_seq_o            (ack_seq_o),
    .fc_valid_o           (fc_valid_o),
    .fc_kind_o            (fc_kind_o),
    .fc_type_o            (fc_type_o),
    .fc_vc_o              (fc_vc_o),
    .fc_hdr_o             (fc_hdr_o),
    .fc_data_o            (fc_data_o),
    .bad_dllp_o           (bad_dllp_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          low_cnt = 0;
  bit          cnt_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          fc_hi[9] = '{4, 5, 6, 12, 13, 14, 8, 9, 10};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Event log: {cycle, tag, fields}; tag 1 Ack/Nak, 2 FC, 3 bad.
  always @(negedge clk_i) begin
    if (cnt_en && !tready) low_cnt <= low_cnt + 1;
    if (!rst_i && (ack_valid_o || fc_valid_o || bad_dllp_o)) begin
      check("strobe_exclusive", 64'($countones({ack_valid_o, fc_valid_o, bad_dllp_o})), 64'd1);
      if (bad_dllp_o)      got_q.push_back({24'(cyc), 4'd3, 36'd0});
      else if (ack_valid_o) got_q.push_back({24'(cyc), 4'd1, 23'd0, ack_nak_o, ack_seq_o});
      else got_q.push_back({24'(cyc), 4'd2, 9'd0, fc_kind_o, fc_type_o, fc_vc_o, fc_hdr_o,
                            fc_data_o});
    end
  end

  function automatic logic [15:0] ref_crc(input logic [31:0] w);
    int unsigned c = 'hffff;
    int unsigned b4 = 0;
    int unsigned b5 = 0;
    for (int i = 0; i < 32; i++) begin
      int unsigned top = (c >> 15) & 1;
      int unsigned bit_i = (w >> i) & 1;
      c = (c << 1) & 'hffff;
      if ((top ^ bit_i) != 0) c = c ^ 'h100b;
    end
    c = c ^ 'hffff;
    for (int j = 0; j < 8; j++) begin
      if (((c >> (15 - j)) & 1) != 0) b4 = b4 | (1 << j);
      if (((c >> (7 - j)) & 1) != 0) b5 = b5 | (1 << j);
    end
    return 16'(b5 * 256 + b4);
  endfunction

  // Expected outcome of a well-framed DLLP; tag 0 means silently dropped.
  function automatic logic [39:0] predict(input logic [31:0] w, input logic [15:0] crc,
                                          input logic [1:0] link);
    int unsigned b0 = w & 'hff;
    int unsigned b1 = (w >> 8) & 'hff;
    int unsigned b2 = (w >> 16) & 'hff;
    int unsigned b3 = (w >> 24) & 'hff;
    int unsigned hi = b0 / 16;
    int unsigned kind = 0;
    int unsigned typ = 0;
    int unsigned seq = (b2 % 16) * 256 + b3;
    int unsigned hdr = (b1 % 64) * 4 + b2 / 64;
    if (CrcEn && ref_crc(w) != crc) return {4'd3, 36'd0};
    if (b0 == 0 || b0 == 16) begin
      if (link == 2) return {4'd1, 23'd0, 1'(b0 / 16), 12'(seq)};
      return '0;
    end
    if (b0 % 16 < 8) begin
      if (hi >= 4 && hi <= 6) begin kind = 1; typ = hi - 4; end
      else if (hi >= 12 && hi <= 14) begin kind = 2; typ = hi - 12; end
      else if (hi >= 8 && hi <= 10) begin kind = 3; typ = hi - 8; end
    end
    if (kind != 0 && (link == 1 || link == 2))
      return {4'd2, 9'd0, 2'(kind), 2'(typ), 3'(b0 % 8), 8'(hdr), 12'(seq)};
    return '0;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input int max_gap, output int hs);
    int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      tvalid = 1'b0;
      @(posedge clk_i); #1;
    end
    tdata = d; tkeep = k; tlast = l; tuser = 4'($urandom); tvalid = 1'b1;
    hs = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (tready) begin
        hs = cyc + 1;
        break;
      end
    end
    if (hs < 0) check("handshake_timeout", 64'd1, 64'd0);
    @(posedge clk_i); #1;
    tvalid = 1'b0;
  endtask

  // ptype 0: legal 2-beat, 1: single beat with tlast, 2: 3-beat with early tlast missing.
  task automatic send_pkt(input int ptype, input logic [31:0] w, input logic [15:0] crc,
                          input logic [1:0] link, input int max_gap);
    int h1, h2, h3;
    logic [39:0] p;
    link_status_i = link;
    if (ptype == 1) begin
      send_beat(w, 4'hf, 1'b1, max_gap, h1);
      exp_q.push_back({24'(h1), 4'd3, 36'd0});
    end else begin
      send_beat(w, 4'hf, 1'b0, max_gap, h1);
      if (ptype == 0) begin
        send_beat({16'($urandom), crc}, 4'h3, 1'b1, max_gap, h2);
        p = predict(w, crc, link);
        if (p[39:36] != 4'd0) exp_q.push_back({24'(h2), p});
      end else begin
        send_beat($urandom, ($urandom_range(0, 1) == 1) ? 4'h3 : 4'($urandom), 1'b0, max_gap, h2);
        exp_q.push_back({24'(h2), 4'd3, 36'd0});
        send_beat($urandom, 4'($urandom), 1'b1, max_gap, h3);
      end
    end
  endtask

  task automatic flush_cmp(input string tag);
    int n;
    tvalid = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] rand_b0();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'h10;
    if (r <= 7) return 8'(fc_hi[$urandom_range(0, 8)] * 16 + $urandom_range(0, 7));
    if (r == 8) return ($urandom_range(0, 1) == 1) ? 8'h20 : 8'h30;
    return 8'($urandom);
  endfunction

  logic [31:0] w;
  logic [15:0] crc;
  int          h, lo0, ptype;

  initial begin
    // Reset behaviour.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_tready", 64'(tready), 64'd0);
    check("rst_outputs", {ack_valid_o, ack_nak_o, ack_seq_o, fc_valid_o, fc_kind_o, fc_type_o,
                          fc_vc_o, fc_hdr_o, fc_data_o, bad_dllp_o}, 64'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_tready", 64'(tready), 64'd1);
    check("post_rst_outputs", {ack_valid_o, fc_valid_o, bad_dllp_o}, 64'd0);
    @(posedge clk_i); #1;

    // Ack seq 0x123 on an active link.
    w = 32'h2301_0000;
    send_pkt(0, w, ref_crc(w), 2'b10, 0);
    flush_cmp("ack123");
    check("ack_seq_hold", 64'(ack_seq_o), 64'h123);

    // InitFC1-NP VC0 Hdr 0x20 Data 0x040 under init, then Nak under init is dropped.
    w = 32'h4000_0850;
    send_pkt(0, w, ref_crc(w), 2'b01, 0);
    flush_cmp("initfc1");
    check("fc_fields", {fc_kind_o, fc_type_o, fc_vc_o, fc_hdr_o, fc_data_o},
          {2'b01, 2'b01, 3'd0, 8'h20, 12'h040});
    check("ack_seq_hold2", 64'(ack_seq_o), 64'h123);
    w = 32'h0500_0010;
    send_pkt(0, w, ref_crc(w), 2'b01, 0);
    flush_cmp("nak_init");

    // Framing errors followed by a legal DLLP.
    w = 32'h4400_0000;
    send_pkt(1, w, 16'h0, 2'b10, 0);
    send_pkt(0, w, ref_crc(w), 2'b10, 0);
    send_pkt(2, w, ref_crc(w), 2'b10, 1);
    flush_cmp("framing");

    // UpdateFC-Cpl with one CRC bit flipped.
    w = 32'h5a6b_7ca3;
    send_pkt(0, w, ref_crc(w) ^ 16'h0001, 2'b10, 0);
    flush_cmp("crc_flip");

    // Reset while waiting for beat 2, then a fresh Ack and an unknown type.
    link_status_i = 2'b10;
    send_beat(32'h0F00_0000, 4'hf, 1'b0, 0, h);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    w = 32'h7702_0000;
    send_pkt(0, w, ref_crc(w), 2'b10, 0);
    w = 32'h1111_1120;
    send_pkt(0, w, ref_crc(w), 2'b10, 0);
    flush_cmp("rst_beat2");

    // Back-to-back burst: one ISSUE cycle of tready low per DLLP.
    lo0 = low_cnt;
    cnt_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = {24'($urandom), (i % 2 == 0) ? 8'h10 : 8'h91};
      send_pkt(0, w, ref_crc(w), 2'b10, 0);
    end
    @(posedge clk_i); #1;
    cnt_en = 1'b0;
    check("burst_tready_low", 64'(low_cnt - lo0), 64'd6);
    flush_cmp("burst");

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      ptype = $urandom_range(0, 9);
      ptype = (ptype < 8) ? 0 : ptype - 7;
      w = {24'($urandom), rand_b0()};
      crc = ref_crc(w);
      if ($urandom_range(0, 6) == 0) crc = crc ^ 16'(1 << $urandom_range(0, 15));
      send_pkt(ptype, w, crc, 2'($urandom_range(0, 3)), 2);
      if (i % 10 == 9) flush_cmp("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
